// File: rtl/matrix8x_frame_capture_pkg.sv
// Shared constants and types for the LED-matrix frame capture block.
package matrix_pkg;

  localparam int MATRIX_COLS = 8;
  localparam int MATRIX_ROWS = 8;
  localparam int COL_W       = 3;

  localparam logic [MATRIX_ROWS-1:0] BLANK_SEG = 8'hFF;

  typedef logic [COL_W-1:0]       col_t;
  typedef logic [MATRIX_ROWS-1:0] row_t;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } cap_state_e;

endpackage

// File: rtl/matrix8x_frame_capture_scan_settle_filter.sv
// Registers the scanner buses, waits for a stable column select before
// issuing one capture strobe per dwell, and flags a stalled scan.
module scan_settle_filter
  import matrix_pkg::*;
#(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] segin,
  input  logic [2:0] scanin,
  output logic       cap_strobe,
  output logic [2:0] cap_col,
  output logic [7:0] cap_data,
  output logic       scan_stalled
);

  localparam int STAB_W = $clog2(SETTLE + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(SETTLE);
  localparam logic [STAB_W-1:0] STAB_FIRE = STAB_W'(SETTLE - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);

  row_t              seg_q, seg_d;
  col_t              scan_q, scan_d;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              scan_chg;

  always_comb begin
    seg_d      = segin;
    scan_d     = scanin;
    scan_chg   = (scanin != scan_q);
    stab_cnt_d = stab_cnt_q;
    idle_cnt_d = idle_cnt_q;
    // Both counters restart on the edge that loads a new column into scan_q.
    if (scan_chg) begin
      stab_cnt_d = '0;
      idle_cnt_d = '0;
    end else begin
      if (stab_cnt_q != STAB_MAX) stab_cnt_d = stab_cnt_q + 1'b1;
      if (idle_cnt_q != IDLE_MAX) idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q      <= BLANK_SEG;
      scan_q     <= '0;
      stab_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      seg_q      <= seg_d;
      scan_q     <= scan_d;
      stab_cnt_q <= stab_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // The count passes SETTLE-1 exactly once per dwell, so this is a single pulse.
  assign cap_strobe   = (stab_cnt_q == STAB_FIRE);
  assign cap_col      = scan_q;
  assign cap_data     = ~seg_q;
  assign scan_stalled = (idle_cnt_q == IDLE_MAX);

endmodule

// File: rtl/matrix8x_frame_capture.sv
// Rebuilds the scanned 8x8 frame, commits complete in-order frames and
// reports changes, sequence errors and stalled scanning.
module matrix8x_frame_capture
  import matrix_pkg::*;
#(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  segin,
  input  logic [2:0]  scanin,
  output logic [63:0] frame_out,
  output logic        frame_valid,
  output logic        frame_changed,
  output logic [7:0]  frame_count,
  output logic        seq_error,
  output logic        scan_stalled
);

  localparam col_t COL_FIRST = '0;
  localparam col_t COL_LAST  = col_t'(MATRIX_COLS - 1);

  typedef logic [MATRIX_COLS-1:0][MATRIX_ROWS-1:0] frame_t;

  logic cap_strobe;
  col_t cap_col;
  row_t cap_data;
  logic stalled;

  cap_state_e state_q, state_d;
  col_t       expect_q, expect_d;
  frame_t     shadow_q, shadow_d;
  frame_t     frame_q, frame_d;
  logic       commit_q, commit_d;
  logic       valid_q, valid_d;
  logic       changed_q, changed_d;
  logic [7:0] count_q, count_d;

  scan_settle_filter #(
    .SETTLE  (SETTLE),
    .TIMEOUT (TIMEOUT)
  ) u_filter (
    .clk          (clk),
    .reset        (reset),
    .segin        (segin),
    .scanin       (scanin),
    .cap_strobe   (cap_strobe),
    .cap_col      (cap_col),
    .cap_data     (cap_data),
    .scan_stalled (stalled)
  );

  always_comb begin
    state_d   = state_q;
    expect_d  = expect_q;
    shadow_d  = shadow_q;
    frame_d   = frame_q;
    commit_d  = 1'b0;
    valid_d   = 1'b0;
    changed_d = 1'b0;
    count_d   = count_q;
    seq_error = 1'b0;

    if (commit_q) begin
      frame_d   = shadow_q;
      valid_d   = 1'b1;
      changed_d = (shadow_q != frame_q);
      count_d   = count_q + 8'd1;
    end

    // A stall outranks any capture landing in the same cycle.
    if (stalled) begin
      state_d = HUNT;
    end else if (cap_strobe) begin
      unique case (state_q)
        HUNT: begin
          if (cap_col == COL_FIRST) begin
            shadow_d[COL_FIRST] = cap_data;
            expect_d            = col_t'(1);
            state_d             = COLLECT;
          end
        end
        COLLECT: begin
          if (cap_col == expect_q) begin
            shadow_d[cap_col] = cap_data;
            expect_d          = expect_q + 1'b1;
            commit_d          = (cap_col == COL_LAST);
          end else begin
            seq_error = 1'b1;
            if (cap_col == COL_FIRST) begin
              shadow_d[COL_FIRST] = cap_data;
              expect_d            = col_t'(1);
            end else begin
              state_d = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= HUNT;
      expect_q  <= '0;
      shadow_q  <= '0;
      frame_q   <= '0;
      commit_q  <= 1'b0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      expect_q  <= expect_d;
      shadow_q  <= shadow_d;
      frame_q   <= frame_d;
      commit_q  <= commit_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      count_q   <= count_d;
    end
  end

  assign frame_out     = frame_q;
  assign frame_valid   = valid_q;
  assign frame_changed = changed_q;
  assign frame_count   = count_q;
  assign scan_stalled  = stalled;

endmodule

// File: tb/tb_matrix8x_frame_capture.sv
// Scoreboard bench: each scanner dwell feeds a frame-level reference model
// whose expected commits and sequence errors a negedge monitor checks.
module tb_matrix8x_frame_capture;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 65536;
  localparam int DWELL   = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  segin;
  logic [2:0]  scanin;
  logic [63:0] frame_out;
  logic        frame_valid;
  logic        frame_changed;
  logic [7:0]  frame_count;
  logic        seq_error;
  logic        scan_stalled;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [63:0] frame;
    logic        changed;
    logic [7:0]  count;
    int unsigned at_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned err_q[$];

  logic [7:0]  m_cols [8];
  bit          m_collect;
  int          m_expect;
  logic [63:0] m_prev;
  int          m_count;

  logic [7:0]  pat     [8] = '{8'hFF, 8'h81, 8'hEF, 8'h81, 8'hED, 8'hDD, 8'hDD, 8'h00};
  logic [7:0]  cur_pat [8];

  matrix8x_frame_capture #(
    .SETTLE  (SETTLE),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .segin         (segin),
    .scanin        (scanin),
    .frame_out     (frame_out),
    .frame_valid   (frame_valid),
    .frame_changed (frame_changed),
    .frame_count   (frame_count),
    .seq_error     (seq_error),
    .scan_stalled  (scan_stalled)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [63:0] packFrame();
    logic [63:0] f;
    for (int c = 0; c < 8; c++) f[8*c +: 8] = m_cols[c];
    return f;
  endfunction

  function automatic void modelReset();
    for (int c = 0; c < 8; c++) m_cols[c] = 8'h00;
    m_collect = 0;
    m_expect  = 0;
    m_prev    = '0;
    m_count   = 0;
  endfunction

  // One dwell of the scanner starting at cycle 'start': a dwell of at least
  // SETTLE cycles is one capture; one longer than TIMEOUT also stalls the scan.
  function automatic void modelDwell(int col, logic [7:0] seg, int len, int unsigned start);
    logic [63:0] f;
    exp_t e;
    if (len >= SETTLE) begin
      if (!m_collect) begin
        if (col == 0) begin
          m_cols[0] = ~seg;
          m_expect  = 1;
          m_collect = 1;
        end
      end else if (col == m_expect) begin
        m_cols[col] = ~seg;
        if (col == 7) begin
          f         = packFrame();
          e.frame   = f;
          e.changed = (f != m_prev);
          e.count   = 8'((m_count + 1) % 256);
          e.at_cyc  = start + SETTLE + 2;
          exp_q.push_back(e);
          m_prev    = f;
          m_count   = m_count + 1;
          m_expect  = 0;
        end else begin
          m_expect = m_expect + 1;
        end
      end else begin
        err_q.push_back(start + SETTLE);
        if (col == 0) begin
          m_cols[0] = ~seg;
          m_expect  = 1;
        end else begin
          m_collect = 0;
        end
      end
    end
    if (len >= TIMEOUT + 1) m_collect = 0;
  endfunction

  // Called just after a rising edge; holds the column for exactly len edges.
  task automatic applyStimulus(input int col, input logic [7:0] seg, input int len);
    modelDwell(col, seg, len, cyc);
    scanin = 3'(col);
    segin  = seg;
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic scanCols(input int first, input int last);
    for (int c = first; c <= last; c++) applyStimulus(c, cur_pat[c], DWELL);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_frame_out"}, frame_out, 64'h0);
    checkOutput({tag, "_frame_valid"}, 64'(frame_valid), 64'h0);
    checkOutput({tag, "_frame_changed"}, 64'(frame_changed), 64'h0);
    checkOutput({tag, "_frame_count"}, 64'(frame_count), 64'h0);
    checkOutput({tag, "_seq_error"}, 64'(seq_error), 64'h0);
    checkOutput({tag, "_scan_stalled"}, 64'(scan_stalled), 64'h0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a commit or error.
  logic [63:0] held = '0;
  exp_t        mon_e;
  int unsigned mon_c;

  always @(negedge clk) begin
    if (reset) begin
      held = '0;
    end else begin
      if (frame_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_frame_valid", 64'(frame_valid), 64'h0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("frame_out", frame_out, mon_e.frame);
          checkOutput("frame_changed", 64'(frame_changed), 64'(mon_e.changed));
          checkOutput("frame_count", 64'(frame_count), 64'(mon_e.count));
          checkOutput("commit_cycle", 64'(cyc), 64'(mon_e.at_cyc));
          held = mon_e.frame;
        end
      end else begin
        checkOutput("frame_held", frame_out, held);
      end
      if (seq_error) begin
        if (err_q.size() == 0) begin
          checkOutput("unexpected_seq_error", 64'(seq_error), 64'h0);
        end else begin
          mon_c = err_q.pop_front();
          checkOutput("seq_error_cycle", 64'(cyc), 64'(mon_c));
        end
      end
    end
  end

  initial begin
    int pos;
    int last;
    int r;
    int col;
    int len;

    modelReset();
    reset  = 1'b1;
    scanin = 3'd5;
    segin  = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    reset = 1'b0;
    applyStimulus(5, 8'hFF, 2);

    // Reference pattern, repeated, then shifted by one column.
    cur_pat = pat;
    scanCols(0, 7);
    checkOutput("t1_frame", frame_out, 64'hFF22_2212_7E10_7E00);
    checkOutput("t1_count", 64'(frame_count), 64'd1);
    scanCols(0, 7);
    checkOutput("t2_count", 64'(frame_count), 64'd2);
    for (int c = 0; c < 8; c++) cur_pat[c] = pat[(c + 7) % 8];
    scanCols(0, 7);
    checkOutput("t2_shift_count", 64'(frame_count), 64'd3);

    // A short glitch on column 5 between columns 2 and 3 is ignored.
    for (int c = 0; c < 8; c++) cur_pat[c] = pat[7 - c];
    scanCols(0, 2);
    applyStimulus(5, 8'h00, 2);
    scanCols(3, 7);
    checkOutput("t3_count", 64'(frame_count), 64'd4);

    // Skipped column: error, no commit, then a clean frame commits.
    for (int c = 0; c < 8; c++) cur_pat[c] = 8'(8'h11 * c);
    scanCols(0, 1);
    scanCols(3, 7);
    checkOutput("t4_count_hold", 64'(frame_count), 64'd4);
    checkOutput("t4_frame_hold", frame_out, m_prev);
    scanCols(0, 7);
    checkOutput("t4_count", 64'(frame_count), 64'd5);

    // Stall on column 4 mid-frame; 5..7 afterwards must not complete it.
    for (int c = 0; c < 8; c++) cur_pat[c] = 8'(~(8'h01 << c));
    scanCols(0, 3);
    modelDwell(4, cur_pat[4], TIMEOUT + 10, cyc);
    scanin = 3'd4;
    segin  = cur_pat[4];
    repeat (TIMEOUT) @(posedge clk);
    #1;
    checkOutput("t5_not_yet_stalled", 64'(scan_stalled), 64'h0);
    @(posedge clk);
    #1;
    checkOutput("t5_stalled", 64'(scan_stalled), 64'h1);
    repeat (9) @(posedge clk);
    #1;
    modelDwell(5, cur_pat[5], DWELL, cyc);
    scanin = 3'd5;
    segin  = cur_pat[5];
    @(posedge clk);
    #1;
    checkOutput("t5_unstalled", 64'(scan_stalled), 64'h0);
    repeat (DWELL - 1) @(posedge clk);
    #1;
    scanCols(6, 7);
    checkOutput("t5_count_hold", 64'(frame_count), 64'd5);
    scanCols(0, 7);
    checkOutput("t5_count", 64'(frame_count), 64'd6);

    // Reset after column 4; afterwards a scan from column 3 is ignored.
    for (int c = 0; c < 8; c++) cur_pat[c] = 8'(8'hF0 ^ (8'h0F * c));
    scanCols(0, 4);
    reset = 1'b1;
    modelReset();
    #1;
    checkResetOutputs("t6");
    scanin = 3'd5;
    segin  = 8'hFF;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(5, 8'hFF, 2);
    scanCols(3, 7);
    checkOutput("t6_count_hold", 64'(frame_count), 64'd0);
    scanCols(0, 7);
    checkOutput("t6_count", 64'(frame_count), 64'd1);

    // Random scanning: mostly in order, with glitches and stray columns.
    pos  = 0;
    last = 7;
    for (int i = 0; i < 160; i++) begin
      r = $urandom_range(0, 9);
      if (r < 8) begin
        col = pos;
        len = $urandom_range(SETTLE, SETTLE + 10);
      end else if (r == 8) begin
        col = $urandom_range(0, 7);
        len = $urandom_range(1, SETTLE - 1);
      end else begin
        col = $urandom_range(0, 7);
        len = $urandom_range(SETTLE, SETTLE + 10);
      end
      if (col != last) begin
        applyStimulus(col, 8'($urandom), len);
        last = col;
        if (r < 8) pos = (pos + 1) % 8;
        else if (r == 9) pos = (col + 1) % 8;
      end
    end
    applyStimulus((last + 1) % 8, 8'($urandom), SETTLE + 30);

    checkOutput("pending_commits", 64'(exp_q.size()), 64'h0);
    checkOutput("pending_seq_errors", 64'(err_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
